dmem_arbiter: RTL



---
 rtl/dmem_arbiter.sv | 58 +++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the CPU MEM stage and a debug/loader port
module dmem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_dbg
);
  typedef enum logic [1:0] {CPU, DBG, ACK} state_t;
  state_t state;
  logic [3:0] streak, streak_nxt;
  logic cpu_use, dbg, go;
  assign cpu_use = cpu_mem_read | cpu_mem_write;
  assign dbg = state == DBG;
  always_comb begin
    streak_nxt = !dbg_req ? 4'd0 : (cpu_use && streak != 4'hf) ? streak + 4'd1 : streak;
    // ACK hands memory back to the CPU, so it arbitrates exactly like CPU
    go = !dbg && dbg_req && (!cpu_use || streak_nxt >= 4'(MAX_CPU_BURST));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CPU;
      streak <= '0;
      dbg_rdata <= '0;
    end else begin
      state <= go ? DBG : dbg ? ACK : CPU;
      streak <= (!dbg && !go) ? streak_nxt : 4'd0;
      dbg_rdata <= (dbg && !dbg_we) ? mem_rdata : dbg_rdata;
    end
  end
  assign mem_addr = dbg ? dbg_addr : cpu_addr;
  assign mem_wdata = dbg ? dbg_wdata : cpu_wdata;
  assign mem_write = !reset && (dbg ? dbg_we : cpu_mem_write);
  assign mem_read = !reset && (dbg ? !dbg_we : cpu_mem_read && !cpu_mem_write);
  assign cpu_rdata = dbg ? '0 : mem_rdata;
  assign cpu_stall = dbg && cpu_use;
  assign grant_dbg = dbg;
  assign dbg_ack = state == ACK;
endmodule
